// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous memory port between the CPU
// datapath (C) and a debug/DMA loader (D), with starvation and burst control.
module mem_port_arbiter #(
    parameter int AW        = 10,
    parameter int DW        = 32,
    parameter int MAX_WAIT  = 8,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_stall,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic          dma_lock,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        PRI_CPU  = 1'b0,
        LOCKED_D = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [WW-1:0] r_wait_cnt;
    logic [WW-1:0] w_wait_nxt;
    logic [BW-1:0] r_burst_cnt;
    logic [BW-1:0] w_burst_nxt;
    logic          r_cpu_rd;
    logic          r_dma_rd;
    logic          w_starve;
    logic          w_cpu_gnt;
    logic          w_dma_gnt;

    assign w_starve = (r_wait_cnt == WW'(MAX_WAIT));

    // Grant selection; reset holds both grants low.
    always_comb begin
        w_cpu_gnt = 1'b0;
        w_dma_gnt = 1'b0;
        if (!rst) begin
            case (r_state)
                PRI_CPU: begin
                    w_dma_gnt = dma_req & (w_starve | ~cpu_req);
                    w_cpu_gnt = cpu_req & ~w_dma_gnt;
                end
                LOCKED_D: begin
                    w_dma_gnt = dma_req;
                    w_cpu_gnt = cpu_req & ~dma_req;
                end
                default: begin
                    w_cpu_gnt = 1'b0;
                    w_dma_gnt = 1'b0;
                end
            endcase
        end
    end

    // Starvation and burst counters, next values.
    always_comb begin
        w_wait_nxt  = '0;
        w_burst_nxt = '0;
        if (dma_req && !w_dma_gnt) begin
            w_wait_nxt = w_starve ? r_wait_cnt : r_wait_cnt + WW'(1);
        end
        if (w_dma_gnt) begin
            if (r_burst_cnt == BW'(MAX_BURST)) begin
                w_burst_nxt = r_burst_cnt;
            end else begin
                w_burst_nxt = r_burst_cnt + BW'(1);
            end
        end
    end

    // Lock entry/exit; a burst that reaches its limit drops back to CPU priority.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            PRI_CPU: begin
                if (w_dma_gnt && dma_lock &&
                    (r_burst_cnt < BW'(MAX_BURST - 1))) begin
                    w_state_nxt = LOCKED_D;
                end
            end
            LOCKED_D: begin
                if (!dma_lock || !dma_req ||
                    (w_burst_nxt == BW'(MAX_BURST))) begin
                    w_state_nxt = PRI_CPU;
                end
            end
            default: w_state_nxt = PRI_CPU;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= PRI_CPU;
            r_wait_cnt  <= '0;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_wait_cnt  <= w_wait_nxt;
            r_burst_cnt <= w_burst_nxt;
        end
    end

    // Read owner: remembers which port's read is returning next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cpu_rd <= 1'b0;
            r_dma_rd <= 1'b0;
        end else begin
            r_cpu_rd <= w_cpu_gnt & ~cpu_we;
            r_dma_rd <= w_dma_gnt & ~dma_we;
        end
    end

    // Memory port steering; idle port drives zeros.
    always_comb begin
        mem_en    = w_cpu_gnt | w_dma_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (w_dma_gnt) begin
            mem_we    = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end
    end

    assign cpu_gnt    = w_cpu_gnt;
    assign dma_gnt    = w_dma_gnt;
    assign cpu_stall  = cpu_req & ~w_cpu_gnt & ~rst;
    assign cpu_rvalid = r_cpu_rd & ~rst;
    assign dma_rvalid = r_dma_rd & ~rst;
    assign cpu_rdata  = rst ? '0 : mem_rdata;
    assign dma_rdata  = rst ? '0 : mem_rdata;

endmodule
